// File: rtl/btn_gpio_pkg.sv
// Shared constants and helpers for the push-button / switch input GPIO block.
package btn_gpio_pkg;

    // Word offsets selected by addr[3:2]
    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_RISE_EN = 2'd2;
    localparam logic [1:0] REG_FALL_EN = 2'd3;

    // Base address of this peripheral, used by the system address decoder
    localparam logic [31:0] BASE_ADDR = 32'h1000_0010;

    // Expand the four byte-lane strobes into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] strobe);
        return {{8{strobe[3]}}, {8{strobe[2]}}, {8{strobe[1]}}, {8{strobe[0]}}};
    endfunction

endpackage

// File: rtl/btn_gpio_in_debounce.sv
// Per-pin input conditioning: two-flop synchroniser, debounce counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing
// samples, and a one-cycle rise/fall edge detector on the accepted level.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_async,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_async;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count cycles the synchronised level differs from the accepted one
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync2_q == stable_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Delayed copy of the accepted level for edge detection
    always_ff @(posedge clk) begin
        if (rst) stable_d_q <= 1'b0;
        else     stable_d_q <= stable_q;
    end

    assign stable = stable_q;
    assign rise   = stable_q & ~stable_d_q;
    assign fall   = ~stable_q & stable_d_q;

endmodule

// File: rtl/btn_gpio_in.sv
// Memory-mapped input GPIO: debounced pin levels, sticky W1C edge status,
// rise/fall enables, registered read port and a level interrupt.
module btn_gpio_in
    import btn_gpio_pkg::*;
#(
    parameter int N_IN            = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic [31:0]     data_in,
    input  logic            rd_strobe,
    input  logic [3:0]      wr_strobe,
    output logic [31:0]     data_out,
    input  logic [N_IN-1:0] pins,
    output logic            irq
);

    logic [N_IN-1:0] stable, rise, fall;
    logic [N_IN-1:0] status_q, status_d;
    logic [N_IN-1:0] rise_en_q, rise_en_d;
    logic [N_IN-1:0] fall_en_q, fall_en_d;
    logic [31:0]     data_out_q;
    logic [31:0]     rd_val;
    logic [31:0]     wmask;
    logic [N_IN-1:0] wmask_n, wdata_n, clr;
    logic [1:0]      sel;
    logic            wr_any;
    logic            unused_bits;

    // One conditioning pipeline per pin
    for (genvar i = 0; i < N_IN; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .pin_async(pins[i]),
            .stable   (stable[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    assign sel     = addr[3:2];
    assign wr_any  = |wr_strobe;
    assign wmask   = lane_mask(wr_strobe);
    assign wmask_n = wmask[N_IN-1:0];
    assign wdata_n = data_in[N_IN-1:0] & wmask_n;
    assign unused_bits = &{1'b0, addr[31:4], addr[1:0], data_in};

    // Next-state for the register file; a new edge overrides a same-cycle clear
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_any) begin
            case (sel)
                REG_STATUS:  clr       = wdata_n;
                REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask_n) | wdata_n;
                REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask_n) | wdata_n;
                default:     ;
            endcase
        end
        status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    // Register file update
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            status_q  <= status_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
        end
    end

    // Read mux over the pre-write register values, zero-extended to 32 bits
    always_comb begin
        rd_val = '0;
        case (sel)
            REG_STATE:   rd_val = 32'(stable);
            REG_STATUS:  rd_val = 32'(status_q);
            REG_RISE_EN: rd_val = 32'(rise_en_q);
            REG_FALL_EN: rd_val = 32'(fall_en_q);
            default:     rd_val = '0;
        endcase
    end

    // Registered read data, held while no read is requested
    always_ff @(posedge clk) begin
        if (rst)            data_out_q <= '0;
        else if (rd_strobe) data_out_q <= rd_val;
    end

    assign data_out = data_out_q;
    assign irq      = |status_q;

endmodule

// File: tb/tb_btn_gpio_in.sv
// Directed bench for btn_gpio_in with DEBOUNCE_CYCLES=4, N_IN=8.
// Inputs are driven on the falling edge and outputs checked on the falling
// edge, so every posedge sees settled stimulus.
module tb_btn_gpio_in;

    localparam int N_IN = 8;
    localparam int DB   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        rd_strobe;
    logic [3:0]  wr_strobe;
    logic [31:0] data_out;
    logic [7:0]  pins;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    btn_gpio_in #(.N_IN(N_IN), .DEBOUNCE_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .rd_strobe(rd_strobe),
        .wr_strobe(wr_strobe),
        .data_out (data_out),
        .pins     (pins),
        .irq      (irq)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver: one write cycle; returns on the falling edge after the write edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        addr = a; data_in = d; wr_strobe = s;
        @(negedge clk);
        wr_strobe = 4'b0000;
    endtask

    // Driver: one read cycle; d is data_out after the capturing edge
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
        d = data_out;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++;
        if (data_out !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h want 0", data_out); end
        for (int r = 0; r < 4; r++) begin
            bus_read(32'(r * 4), d);
            n_cmp++;
            if (d !== 32'h0) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00000000", r, d); end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        bus_write(32'h8, 32'h01, 4'hF);
        pins[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL db_irq_early: got %b want 0", irq); end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL db_irq_set: got %b want 1", irq); end
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL db_state: got %h want 00000001", d); end
        bus_read(32'h4, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL db_status: got %h want 00000001", d); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_out !== 32'h01) begin n_err++; $display("FAIL db_hold: got %h want 00000001", data_out); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        bus_write(32'h8, 32'h03, 4'hF);
        pins[1] = 1'b1;
        repeat (3) @(negedge clk);
        pins[1] = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL gl_state: got %h want 00000001", d); end
        bus_read(32'h4, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL gl_status: got %h want 00000001", d); end
    endtask

    task automatic test_fall_w1c();
        logic [31:0] d;
        bus_write(32'hC, 32'h01, 4'hF);
        bus_write(32'h4, 32'hFF, 4'hF);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_all_irq: got %b want 0", irq); end
        pins[0] = 1'b0;
        repeat (10) @(negedge clk);
        bus_read(32'h4, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL fall_status: got %h want 00000001", d); end
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h00) begin n_err++; $display("FAIL fall_state: got %h want 00000000", d); end
        bus_write(32'h4, 32'h00, 4'hF);
        bus_read(32'h4, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL w1c_zero: got %h want 00000001", d); end
        // Simultaneous read and clear of STATUS
        @(negedge clk);
        addr = 32'h4; data_in = 32'h01; wr_strobe = 4'hF; rd_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 4'h0; rd_strobe = 1'b0;
        n_cmp++;
        if (data_out !== 32'h01) begin n_err++; $display("FAIL rw_prewrite: got %h want 00000001", data_out); end
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq: got %b want 0", irq); end
        bus_read(32'h4, d);
        n_cmp++;
        if (d !== 32'h00) begin n_err++; $display("FAIL w1c_status: got %h want 00000000", d); end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        bus_write(32'h8, 32'h07, 4'hF);
        pins[2] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL col_irq_early: got %b want 0", irq); end
        addr = 32'h4; data_in = 32'h04; wr_strobe = 4'hF;
        @(negedge clk);
        wr_strobe = 4'h0;
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL col_irq: got %b want 1", irq); end
        bus_read(32'h4, d);
        n_cmp++;
        if (d !== 32'h04) begin n_err++; $display("FAIL col_status: got %h want 00000004", d); end
    endtask

    task automatic test_lanes_reset();
        logic [31:0] d;
        bus_write(32'h8, 32'h00, 4'hF);
        bus_write(32'h8, 32'hFFFF_FFFF, 4'b0010);
        bus_read(32'h8, d);
        n_cmp++;
        if (d !== 32'h00) begin n_err++; $display("FAIL lane1_rise: got %h want 00000000", d); end
        bus_write(32'hC, 32'hFFFF_FF5A, 4'b0001);
        bus_read(32'hC, d);
        n_cmp++;
        if (d !== 32'h5A) begin n_err++; $display("FAIL lane0_fall: got %h want 0000005a", d); end
        bus_write(32'h0, 32'hFF, 4'hF);
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h04) begin n_err++; $display("FAIL state_ro: got %h want 00000004", d); end
        // Reset in the middle of a debounce count on pin 3
        pins[3] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
        repeat (4) @(negedge clk);
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h00) begin n_err++; $display("FAIL rst_restart: got %h want 00000000", d); end
        bus_read(32'h0, d);
        n_cmp++;
        if (d !== 32'h0C) begin n_err++; $display("FAIL rst_settled: got %h want 0000000c", d); end
        bus_read(32'hC, d);
        n_cmp++;
        if (d !== 32'h00) begin n_err++; $display("FAIL rst_fall_en: got %h want 00000000", d); end
    endtask

    initial begin
        rst = 1'b1; addr = '0; data_in = '0; rd_strobe = 1'b0; wr_strobe = 4'h0; pins = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_debounce();
        test_glitch();
        test_fall_w1c();
        test_collision();
        test_lanes_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
